// File: rtl/mul_wb_queue_if.sv
// Multiplier writeback types and the bundle between the multiplier, the queue and the writeback port.
// Latency: none, type and wiring definitions only.
// Backpressure: IN_uop cannot be stalled; the queue throttles issue through OUT_busy.

package mul_wb_pkg;

    localparam int SQN_W = 7;

    // Branch resolution broadcast: taken plus the sqN of the mispredicted op
    typedef struct packed {
        logic             taken;
        logic [SQN_W-1:0] sqN;
    } BranchProv;

    // Completed multiplier result heading for writeback
    typedef struct packed {
        logic             valid;
        logic [6:0]       tagDst;
        logic [5:0]       nmDst;
        logic [SQN_W-1:0] sqN;
        logic [31:0]      result;
        logic [3:0]       flags;
        logic             doNotCommit;
    } RES_UOp;

endpackage

interface mul_wb_queue_if;
    import mul_wb_pkg::*;

    BranchProv IN_branch;
    RES_UOp    IN_uop;
    logic      IN_stall;
    logic      OUT_busy;
    RES_UOp    OUT_uop;

    // Multiplier side and writeback arbiter: drive results, flushes and stall
    modport master (
        output IN_branch,
        output IN_uop,
        output IN_stall,
        input  OUT_busy,
        input  OUT_uop
    );

    // Queue side
    modport slave (
        input  IN_branch,
        input  IN_uop,
        input  IN_stall,
        output OUT_busy,
        output OUT_uop
    );

endinterface

// File: rtl/mul_wb_queue.sv
// Buffers multiplier results in sqN order while the shared writeback port is busy, dropping flushed ops.
// Latency: 1 cycle from IN_uop to OUT_uop when empty and unstalled (bypass), otherwise one pop per free cycle.
// Backpressure: IN_uop is never stalled; OUT_busy rises early enough to absorb results already in flight.

module mul_wb_queue
    import mul_wb_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int INFLIGHT = 6
) (
    input  logic           clk,
    input  logic           rst,
    mul_wb_queue_if.slave  wb
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    RES_UOp        mem [DEPTH];
    RES_UOp        out_q;

    logic          in_killed;
    logic          head_killed;
    logic          pop;
    logic          pop_live;
    logic          bypass;
    logic          push;
    logic          push_ok;
    logic [CW-1:0] keep;
    logic [CW-1:0] count_pop;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_next;
    logic [PW-1:0] wr_flush;
    logic [PW-1:0] wr_next;
    RES_UOp        out_next;

    // An op is younger than the mispredicted branch when the wrapped sqN distance is positive
    function automatic logic is_killed(input BranchProv br, input logic [SQN_W-1:0] sqn);
        logic [SQN_W-1:0] diff;
        diff = sqn - br.sqN;
        return br.taken && ($signed(diff) > $signed(SQN_W'(0)));
    endfunction

    // Next-state: flush trims the killed suffix, then pop from head, then push at the trimmed tail
    always_comb begin
        keep = count;
        if (wb.IN_branch.taken) begin
            // Entries are in ascending sqN, so the killed ones form a contiguous suffix
            keep = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count) && !is_killed(wb.IN_branch, mem[rd_ptr + PW'(i)].sqN)) begin
                    keep = keep + CW'(1);
                end
            end
        end

        head_killed = is_killed(wb.IN_branch, mem[rd_ptr].sqN);
        in_killed   = is_killed(wb.IN_branch, wb.IN_uop.sqN);

        pop      = !wb.IN_stall && (count != '0);
        // A killed head is already gone via the flush, so the pop has nothing left to remove
        pop_live = pop && !head_killed;
        bypass   = !wb.IN_stall && (count == '0) && wb.IN_uop.valid && !in_killed;
        push     = wb.IN_uop.valid && !in_killed && !bypass;

        count_pop = keep - (pop_live ? CW'(1) : CW'(0));
        rd_next   = rd_ptr + (pop_live ? PW'(1) : PW'(0));
        wr_flush  = wb.IN_branch.taken ? (rd_ptr + keep[PW-1:0]) : wr_ptr;

        push_ok    = push && (count_pop < CW'(DEPTH));
        count_next = count_pop + (push_ok ? CW'(1) : CW'(0));
        wr_next    = wr_flush + (push_ok ? PW'(1) : PW'(0));

        // Pop and bypass are mutually exclusive: bypass needs an empty buffer
        out_next       = out_q;
        out_next.valid = 1'b0;
        if (pop_live) begin
            out_next       = mem[rd_ptr];
            out_next.valid = 1'b1;
        end else if (bypass) begin
            out_next       = wb.IN_uop;
            out_next.valid = 1'b1;
        end
    end

    // Pointer, occupancy and output register update; reset clears everything immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            out_q  <= '0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            out_q  <= out_next;
`ifndef SYNTHESIS
            assert (!(push && !push_ok))
                else $warning("mul_wb_queue: result sqN %0d dropped, buffer full", wb.IN_uop.sqN);
`endif
        end
    end

    // Result storage; contents are meaningless outside the rd..wr window, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_flush] <= wb.IN_uop;
        end
    end

    // Busy is raised while the remaining space can still hold every result already in flight
    assign wb.OUT_busy = (count >= CW'(DEPTH - INFLIGHT));
    assign wb.OUT_uop  = out_q;

endmodule

// File: tb/tb_mul_wb_queue.sv
// Bench for mul_wb_queue: directed scenarios followed by random traffic against a queue model.
// Latency: checks OUT_uop one cycle after each stimulus edge.
// Backpressure: random issue is throttled so the model queue never overflows outside the directed case.

module tb_mul_wb_queue;
    import mul_wb_pkg::*;

    localparam int DEPTH    = 8;
    localparam int INFLIGHT = 6;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    RES_UOp mq[$];
    RES_UOp exp_out;
    bit     exp_vld;

    mul_wb_queue_if wb_if ();

    mul_wb_queue #(.DEPTH(DEPTH), .INFLIGHT(INFLIGHT)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic drive(input bit s, input bit tk, input int bsq,
                         input bit v, input int sq, input logic [31:0] res);
        wb_if.IN_stall           = s;
        wb_if.IN_branch.taken    = tk;
        wb_if.IN_branch.sqN      = 7'(bsq);
        wb_if.IN_uop.valid       = v;
        wb_if.IN_uop.sqN         = 7'(sq);
        wb_if.IN_uop.tagDst      = 7'(sq);
        wb_if.IN_uop.nmDst       = 6'(sq);
        wb_if.IN_uop.result      = res;
        wb_if.IN_uop.flags       = res[3:0];
        wb_if.IN_uop.doNotCommit = 1'b0;
    endtask

    // Killed means strictly younger than the branch within half the 128-entry sqN circle
    function automatic bit m_killed(input int sqn);
        int d;
        if (!wb_if.IN_branch.taken) return 1'b0;
        d = (sqn - int'(wb_if.IN_branch.sqN)) & 127;
        return (d >= 1) && (d <= 63);
    endfunction

    // Advance the model by one clock using the current inputs, then compare after the edge
    task automatic cycle();
        bit     had;
        bit     hk;
        bit     ki;
        bit     byp;
        RES_UOp keepq[$];
        RES_UOp u;
        u   = wb_if.IN_uop;
        had = mq.size() > 0;
        hk  = had && m_killed(int'(mq[0].sqN));
        ki  = m_killed(int'(u.sqN));
        foreach (mq[i]) if (!m_killed(int'(mq[i].sqN))) keepq.push_back(mq[i]);
        mq      = keepq;
        exp_vld = 1'b0;
        byp     = 1'b0;
        if (!wb_if.IN_stall && had) begin
            if (!hk) begin
                exp_out = mq.pop_front();
                exp_vld = 1'b1;
            end
        end else if (!wb_if.IN_stall && u.valid && !ki) begin
            exp_out = u;
            exp_vld = 1'b1;
            byp     = 1'b1;
        end
        if (u.valid && !ki && !byp && mq.size() < DEPTH) mq.push_back(u);

        @(posedge clk);
        #1;
        chk("out_vld", 64'(wb_if.OUT_uop.valid), 64'(exp_vld));
        if (exp_vld) begin
            chk("out_sqn", 64'(wb_if.OUT_uop.sqN), 64'(exp_out.sqN));
            chk("out_res", 64'(wb_if.OUT_uop.result), 64'(exp_out.result));
        end
        chk("count", 64'(dut.count), 64'(mq.size()));
        chk("busy", 64'(wb_if.OUT_busy), 64'(mq.size() >= DEPTH - INFLIGHT));
    endtask

    initial begin
        int  next_sqn;
        bit  s;
        bit  tk;
        bit  v;
        int  bsq;

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        #12;
        chk("rst_vld", 64'(wb_if.OUT_uop.valid), 64'd0);
        chk("rst_count", 64'(dut.count), 64'd0);
        chk("rst_busy", 64'(wb_if.OUT_busy), 64'd0);
        chk("rst_rdptr", 64'(dut.rd_ptr), 64'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_vld", 64'(wb_if.OUT_uop.valid), 64'd0);
        cycle();

        // Bypass of a single result into an empty, unstalled queue
        drive(0, 0, 0, 1, 5, 32'h1234);
        cycle();
        chk("byp_res", 64'(wb_if.OUT_uop.result), 64'h1234);
        chk("byp_count", 64'(dut.count), 64'd0);
        drive(0, 0, 0, 0, 0, 32'h0);
        cycle();

        // Two results buffered under a long stall, then drained in order
        drive(1, 0, 0, 1, 10, 32'hA0);
        cycle();
        drive(1, 0, 0, 1, 11, 32'hA1);
        cycle();
        drive(1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 6; i++) cycle();
        chk("stall_count", 64'(dut.count), 64'd2);
        chk("stall_busy", 64'(wb_if.OUT_busy), 64'd1);
        drive(0, 0, 0, 0, 0, 32'h0);
        cycle();
        chk("drain_first", 64'(wb_if.OUT_uop.sqN), 64'd10);
        cycle();
        chk("drain_second", 64'(wb_if.OUT_uop.sqN), 64'd11);
        chk("drain_count", 64'(dut.count), 64'd0);
        cycle();

        // Flush trims the younger half of a stalled buffer
        for (int i = 20; i < 24; i++) begin
            drive(1, 0, 0, 1, i, 32'(i * 3));
            cycle();
        end
        drive(1, 1, 21, 0, 0, 32'h0);
        cycle();
        chk("flush_count", 64'(dut.count), 64'd2);
        drive(0, 0, 0, 0, 0, 32'h0);
        cycle();
        chk("flush_out0", 64'(wb_if.OUT_uop.sqN), 64'd20);
        cycle();
        chk("flush_out1", 64'(wb_if.OUT_uop.sqN), 64'd21);
        cycle();
        chk("flush_idle", 64'(wb_if.OUT_uop.valid), 64'd0);

        // Flush of the head in the very cycle it pops
        drive(1, 0, 0, 1, 20, 32'h55);
        cycle();
        drive(0, 1, 19, 0, 0, 32'h0);
        cycle();
        chk("popflush_vld", 64'(wb_if.OUT_uop.valid), 64'd0);
        chk("popflush_count", 64'(dut.count), 64'd0);

        // Fill to capacity, then one push too many
        for (int i = 30; i < 38; i++) begin
            drive(1, 0, 0, 1, i, 32'(i));
            cycle();
        end
        chk("full_count", 64'(dut.count), 64'd8);
        drive(1, 0, 0, 1, 38, 32'h38);
        cycle();
        chk("ovf_count", 64'(dut.count), 64'd8);

        // Mid-cycle reset takes effect without waiting for a clock edge
        drive(0, 0, 0, 1, 39, 32'h39);
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        chk("midrst_vld", 64'(wb_if.OUT_uop.valid), 64'd0);
        chk("midrst_count", 64'(dut.count), 64'd0);
        chk("midrst_busy", 64'(wb_if.OUT_busy), 64'd0);
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("rel_vld", 64'(wb_if.OUT_uop.valid), 64'd0);

        // Random traffic with in-order sqN, occasional flushes and stalls
        next_sqn = 40;
        for (int n = 0; n < 600; n++) begin
            s   = ($urandom_range(0, 9) < 3);
            tk  = ($urandom_range(0, 19) == 0);
            bsq = next_sqn - 1 - int'($urandom_range(0, 9));
            v   = ($urandom_range(0, 9) < 6) && (mq.size() < DEPTH - 1);
            drive(s, tk, bsq, v, next_sqn, $urandom);
            cycle();
            if (tk) next_sqn = (bsq + 1) & 127;
            else if (v) next_sqn = (next_sqn + 1) & 127;
        end

        drive(0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < DEPTH + 2; i++) cycle();
        chk("final_count", 64'(dut.count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_wb_queue.md
MUL_WB_QUEUE -- requirements
Module: mul_wb_queue

Interface
REQ-001: The block SHALL have parameter DEPTH, default 8: number of result-buffer entries (power of two, at least 4).
REQ-002: The block SHALL have parameter INFLIGHT, default 6: maximum number of multiplier results already in flight when OUT_busy rises.
REQ-003: Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004: Port rst  in  1: asynchronous, active-low reset.
REQ-005: Port IN_branch  in  BranchProv: branch flush; taken plus sqN of the mispredicted op.
REQ-006: Port IN_uop  in  RES_UOp: multiplier result; valid, tagDst, nmDst, sqN, result, flags, doNotCommit; cannot be back-pressured.
REQ-007: Port IN_stall  in  1: shared writeback port is granted to another unit this cycle.
REQ-008: Port OUT_busy  out  1: tells the multiplier issue logic to stop issuing new ops.
REQ-009: Port OUT_uop  out  RES_UOp: registered result to the writeback port.

Function
REQ-010: An op is "killed" when IN_branch.taken=1 and $signed(op.sqN - IN_branch.sqN) > 0; sqN equal to the branch sqN is not killed.
REQ-011: Entries SHALL be stored in arrival order; because the multiplier completes in order, the entries are also in ascending sqN order.
REQ-012: Occupancy count SHALL range 0..DEPTH and be held in $clog2(DEPTH)+1 bits; read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-013: OUT_busy SHALL equal (count >= DEPTH-INFLIGHT), computed combinationally from the registered count only.
REQ-014: Each cycle with IN_stall=0 and count>0, the head entry SHALL be popped; if the head is not killed, OUT_uop SHALL be loaded with the head entry with valid=1.
REQ-015: Each cycle with IN_stall=0, count=0, IN_uop.valid=1 and IN_uop not killed, IN_uop SHALL bypass directly to OUT_uop (1-cycle latency, no buffer write).
REQ-016: In all other cycles OUT_uop.valid SHALL be 0 next cycle; OUT_uop SHALL never hold valid=1 for two cycles from the same entry.
REQ-017: IN_uop.valid=1 and not killed, and not bypassed under REQ-015, SHALL be written at the tail in the same cycle; simultaneous push and pop SHALL leave count unchanged.
REQ-018: When IN_branch.taken=1, the tail SHALL be moved back to the oldest killed entry, so that all killed entries are removed in one cycle and count drops to match; surviving entries keep their order.
REQ-019: When a flush and a pop occur in the same cycle, a killed head SHALL be discarded and not output, and the count SHALL account for both the pop and the removal.
REQ-020: A killed IN_uop SHALL never be written to the buffer or output.
REQ-021: A push while count=DEPTH and no pop is a protocol violation; the entry SHALL be dropped, count SHALL stay DEPTH, and a simulation-only assertion SHALL fire.
REQ-022: OUT_uop fields other than valid are don't-care when valid=0.
REQ-023: Bypass (REQ-015) and pop (REQ-014) SHALL never occur in the same cycle, so results leave strictly in sqN order.

Reset
REQ-024: While rst=0: count=0, both pointers=0, OUT_uop.valid=0, and OUT_busy=0, all asynchronously.
REQ-025: Buffered entries SHALL be discarded on reset; no output SHALL appear in the first cycle after rst deasserts.
REQ-026: Reset asserted mid-operation SHALL override any push, pop, or flush in that cycle.

Verification
REQ-027: IN_stall=0, one IN_uop with sqN=5 and result=0x1234 -> OUT_uop.valid=1 with result=0x1234 one cycle later; count stays 0.
REQ-028: IN_stall=1 for 8 cycles while 2 results (sqN 10, 11) arrive -> count=2 and OUT_busy=1 (2>=DEPTH-INFLIGHT). Release stall -> sqN 10 then sqN 11 on consecutive cycles, then count=0.
REQ-029: Buffer holds sqN 20,21,22,23 under stall; IN_branch.taken=1 with sqN=21 -> count=2 next cycle; after release, only 20 and 21 are output.
REQ-030: Flush with branch sqN=19 in the same cycle that head sqN 20 pops -> no valid output and count=0 next cycle.
REQ-031: Stall held with 8 pushes -> count=8; a 9th push fires the assertion and count stays 8. Then assert rst=0 mid-cycle -> OUT_uop.valid=0, count=0, OUT_busy=0 immediately.
